// File: rtl/mem_access_unit_if.sv
// Bundles the CPU request/response handshake and the data-memory port of
// mem_access_unit; master is the CPU/memory environment, slave is the unit.
interface mem_access_unit_if #(
  parameter int AW = 11
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic          mem_en;
  logic [3:0]    mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_en, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_en, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and a word-wide data memory:
// address check, big-endian byte-lane write enables and load extraction.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 2048,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, RDWAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_error_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [1:0]  boff_r;

  logic [31:0] off_s;
  logic        accept_s;
  logic        err_s;
  logic        go_s;

  // Byte offset 0 is the most significant lane (big-endian).
  function automatic logic [31:0] extract_load(input logic [31:0] d, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] o);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (o)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    if (o[1]) begin
      h = d[15:0];
    end else begin
      h = d[31:16];
    end
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode, range/alignment check and memory-side drive for the accept cycle.
  always_comb begin
    off_s    = bus.req_addr - BASE_ADDR;
    accept_s = bus.req_valid && (state_r == IDLE);
    err_s    = (off_s >= LIMIT) || (bus.req_size == 2'b11) ||
               ((bus.req_size == 2'b01) && off_s[0]) ||
               ((bus.req_size == 2'b10) && (off_s[1:0] != 2'b00));
    go_s     = accept_s && !err_s && !rst;

    bus.mem_en    = go_s;
    bus.mem_addr  = off_s[AW+1:2];
    bus.mem_write = 4'b0000;
    if (go_s && bus.req_write) begin
      case (bus.req_size)
        2'b00:   bus.mem_write = 4'b0001 << off_s[1:0];
        2'b01:   bus.mem_write = off_s[1] ? 4'b1100 : 4'b0011;
        2'b10:   bus.mem_write = 4'b1111;
        default: bus.mem_write = 4'b0000;
      endcase
    end else begin
      bus.mem_write = 4'b0000;
    end

    case (bus.req_size)
      2'b00:   bus.mem_wdata = {4{bus.req_wdata[7:0]}};
      2'b01:   bus.mem_wdata = {2{bus.req_wdata[15:0]}};
      default: bus.mem_wdata = bus.req_wdata;
    endcase
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_error = resp_error_r;

  // Transaction FSM; response fields are written only when a response is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_error_r <= 1'b0;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      boff_r       <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          if (accept_s) begin
            if (err_s) begin
              resp_error_r <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
              resp_valid_r <= 1'b1;
              state_r      <= RESP;
            end else if (bus.req_write) begin
              resp_error_r <= 1'b0;
              resp_rdata_r <= 32'h0000_0000;
              resp_valid_r <= 1'b1;
              state_r      <= RESP;
            end else begin
              size_r   <= bus.req_size;
              signed_r <= bus.req_signed;
              boff_r   <= off_s[1:0];
              state_r  <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          resp_rdata_r <= extract_load(bus.mem_rdata, size_r, signed_r, boff_r);
          resp_error_r <= 1'b0;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a registered-read data memory model.
module tb_mem_access_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_access_unit_if #(.AW(11)) bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, bit i of mem_write enables byte lane [31-8i -: 8].
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_write[i]) mem[bus.mem_addr][31-8*i -: 8] <= bus.mem_wdata[31-8*i -: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    #1;
  endtask

  task automatic store_txn(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] exp_we,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wd);
    start(1'b1, sz, 1'b0, a, d);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, ".mem_en"}, 32'(bus.mem_en), 32'd1);
    check({tag, ".mem_write"}, 32'(bus.mem_write), 32'(exp_we));
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), exp_addr);
    check({tag, ".mem_wdata"}, bus.mem_wdata, exp_wd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, ".resp_error"}, 32'(bus.resp_error), 32'd0);
    check({tag, ".resp_rdata"}, bus.resp_rdata, 32'h0);
    @(negedge clk);
    check({tag, ".resp_end"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic load_txn(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
    start(1'b0, sz, sg, a, 32'hA5A5_A5A5);
    check({tag, ".mem_en"}, 32'(bus.mem_en), 32'd1);
    check({tag, ".mem_write"}, 32'(bus.mem_write), 32'd0);
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), exp_addr);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, ".wait_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, ".wait_ready"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, ".resp_rdata"}, bus.resp_rdata, exp_data);
    check({tag, ".resp_error"}, 32'(bus.resp_error), 32'd0);
    @(negedge clk);
    check({tag, ".resp_end"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic err_txn(input string tag, input logic w, input logic [1:0] sz,
                         input logic [31:0] a);
    start(w, sz, 1'b1, a, 32'h1234_5678);
    check({tag, ".mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, ".mem_write"}, 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, ".resp_error"}, 32'(bus.resp_error), 32'd1);
    check({tag, ".resp_rdata"}, bus.resp_rdata, 32'h0);
    check({tag, ".mem_en_resp"}, 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    check({tag, ".resp_end"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    logic [5:0] exp_rdy;
    logic [5:0] exp_rsp;
    int         pulses;

    errors = 0;
    checks = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h1001_0000;
    bus.req_wdata  = 32'hFFFF_FFFF;

    repeat (2) @(negedge clk);
    check("rst.mem_en", 32'(bus.mem_en), 32'd0);
    check("rst.mem_write", 32'(bus.mem_write), 32'd0);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'h0);
    check("rst.resp_error", 32'(bus.resp_error), 32'd0);
    check("rst.ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    store_txn("st_word", 2'b10, 32'h1001_0010, 32'hDEAD_BEEF, 4'b1111, 32'd4, 32'hDEAD_BEEF);
    load_txn("ld_word", 2'b10, 1'b0, 32'h1001_0010, 32'd4, 32'hDEAD_BEEF);

    store_txn("st_b0", 2'b00, 32'h1001_0020, 32'h0000_0011, 4'b0001, 32'd8, 32'h1111_1111);
    store_txn("st_b1", 2'b00, 32'h1001_0021, 32'h0000_0022, 4'b0010, 32'd8, 32'h2222_2222);
    store_txn("st_b2", 2'b00, 32'h1001_0022, 32'h0000_0033, 4'b0100, 32'd8, 32'h3333_3333);
    store_txn("st_b3", 2'b00, 32'h1001_0023, 32'hFFFF_FF44, 4'b1000, 32'd8, 32'h4444_4444);
    load_txn("ld_bytes", 2'b10, 1'b0, 32'h1001_0020, 32'd8, 32'h1122_3344);

    store_txn("st_half", 2'b01, 32'h1001_0032, 32'h5555_ABCD, 4'b1100, 32'd12, 32'hABCD_ABCD);
    load_txn("ld_half_u", 2'b01, 1'b0, 32'h1001_0032, 32'd12, 32'h0000_ABCD);
    load_txn("ld_half_s", 2'b01, 1'b1, 32'h1001_0032, 32'd12, 32'hFFFF_ABCD);

    store_txn("st_pat", 2'b10, 32'h1001_0000, 32'h80FF_7F01, 4'b1111, 32'd0, 32'h80FF_7F01);
    load_txn("ld_sb0", 2'b00, 1'b1, 32'h1001_0000, 32'd0, 32'hFFFF_FF80);
    load_txn("ld_ub0", 2'b00, 1'b0, 32'h1001_0000, 32'd0, 32'h0000_0080);
    load_txn("ld_sb1", 2'b00, 1'b1, 32'h1001_0001, 32'd0, 32'hFFFF_FFFF);
    load_txn("ld_sb3", 2'b00, 1'b1, 32'h1001_0003, 32'd0, 32'h0000_0001);
    load_txn("ld_sh2", 2'b01, 1'b1, 32'h1001_0002, 32'd0, 32'h0000_7F01);
    load_txn("ld_sh0", 2'b01, 1'b1, 32'h1001_0000, 32'd0, 32'hFFFF_80FF);
    load_txn("ld_sw_ign", 2'b10, 1'b1, 32'h1001_0000, 32'd0, 32'h80FF_7F01);

    store_txn("st_last", 2'b00, 32'h1001_1FFF, 32'h0000_005A, 4'b1000, 32'd2047, 32'h5A5A_5A5A);
    load_txn("ld_last", 2'b00, 1'b0, 32'h1001_1FFF, 32'd2047, 32'h0000_005A);

    err_txn("err_half_mis", 1'b0, 2'b01, 32'h1001_0001);
    load_txn("ld_after_err", 2'b10, 1'b0, 32'h1001_0010, 32'd4, 32'hDEAD_BEEF);
    err_txn("err_word_mis", 1'b1, 2'b10, 32'h1001_0002);
    err_txn("err_size11", 1'b0, 2'b11, 32'h1001_0000);
    err_txn("err_past_end", 1'b0, 2'b00, 32'h1001_2000);
    err_txn("err_below", 1'b0, 2'b10, 32'h1000_FFFC);
    load_txn("ld_after_errs", 2'b10, 1'b0, 32'h1001_0020, 32'd8, 32'h1122_3344);

    // Back-to-back loads with req_valid held high.
    exp_rdy = 6'b001001;
    exp_rsp = 6'b100100;
    pulses  = 0;
    start(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b2b.ready%0d", k), 32'(bus.req_ready), 32'(exp_rdy[k]));
      check($sformatf("b2b.resp%0d", k), 32'(bus.resp_valid), 32'(exp_rsp[k]));
      if (bus.resp_valid) begin
        pulses++;
        check($sformatf("b2b.data%0d", k), bus.resp_rdata, 32'hDEAD_BEEF);
      end
      if (k < 5) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b.pulses", 32'(pulses), 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("b2b.idle_resp", 32'(bus.resp_valid), 32'd0);
    check("b2b.idle_ready", 32'(bus.req_ready), 32'd1);

    // Reset while waiting for read data.
    start(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstmid.rdwait", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rstmid.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rstmid.ready", 32'(bus.req_ready), 32'd1);
    check("rstmid.mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) pulses++;
    end
    check("rstmid.no_stale", 32'(pulses), 32'd0);
    check("rstmid.ready_after", 32'(bus.req_ready), 32'd1);
    load_txn("ld_after_rst", 2'b10, 1'b0, 32'h1001_0000, 32'd0, 32'h80FF_7F01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the CPU memory stage and the 2048-word data memory.
- Accepts one byte/halfword/word load or store request per transaction and translates the CPU byte address into a word address.
- Generates the big-endian per-byte write-enable bitmap and replicates store data across byte lanes.
- Captures the memory's registered read data, then extracts and sign/zero-extends the addressed field. Out-of-range, misaligned or illegal requests are rejected with an error response and never reach memory.

Parameters:
- BASE_ADDR, 32'h10010000, byte address of data memory word 0.
- DEPTH_WORDS, 2048, memory depth in 32-bit words. mem_addr width = log2(DEPTH_WORDS) = 11.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  load sign-extends when 1, zero-extends when 0
- req_addr  in  32  CPU byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  request rejected (qualifies resp_valid)
- mem_en  out  1  memory chip enable
- mem_write  out  4  byte write bitmap; bit i = byte offset i; bit 0 = bits 31:24, bit 3 = bits 7:0
- mem_addr  out  11  word address
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - All pending captures discarded; reset mid-transaction drops the transaction with no response.
  - mem_en / mem_write are 0 while rst is asserted.
- FSM states: IDLE, RDWAIT, RESP.
  - req_ready = 1 only in IDLE.
  - Request accepted when req_valid & req_ready (cycle T).
- Offset and error checks:
  - off = req_addr - BASE_ADDR, computed in 32 bits unsigned with wrap.
  - Error if any of:
    - off >= 4*DEPTH_WORDS (this also covers addresses below BASE_ADDR);
    - req_size == 11;
    - half with off[0] != 0;
    - word with off[1:0] != 0.
- Memory-side outputs (combinational in T, accepted and non-error only):
  - mem_en = 1, mem_addr = off[12:2].
  - mem_write = 0 for loads. For stores:
    - byte: 4'b0001 << off[1:0];
    - half: off[1]=0 gives 0011, off[1]=1 gives 1100;
    - word: 1111.
  - mem_wdata:
    - byte: {4{req_wdata[7:0]}};
    - half: {2{req_wdata[15:0]}};
    - word: req_wdata.
  - In all other cycles mem_en = 0 and mem_write = 0.
- Error request: no memory access. IDLE->RESP, latched error=1, data=0. resp_valid at T+1.
- Store: IDLE->RESP. resp_valid at T+1, resp_error = 0, resp_rdata = 0.
- Load: IDLE->RDWAIT, latching size, signed and off[1:0].
  - In T+1, extract from mem_rdata:
    - byte at offset o: bits [31-8o -: 8];
    - half at off[1]=0: bits 31:16; off[1]=1: bits 15:0;
    - word: all 32 bits.
  - Extend to 32 bits per the latched req_signed (ignored for word). Register into resp_rdata; go to RESP.
  - resp_valid at T+2.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_rdata / resp_error hold until the next response is written.
  - resp_valid is 0 in all other states.
- Throughput and latency:
  - Load: accept at T, response at T+2, next accept at T+3.
  - Store or error: response at T+1, next accept at T+2.
- No response backpressure; the consumer must take resp_valid when it pulses.
- req_* inputs are ignored when req_ready = 0.
- Boundary: off = 4*DEPTH_WORDS-1 (last byte) is legal; off = 4*DEPTH_WORDS is an error.

Test Plan:
- Word store then load at 0x10010010:
  - store 0xDEADBEEF gives mem_write=1111, mem_addr=4, resp_valid at T+1;
  - load returns 0xDEADBEEF at T+2, resp_error=0.
- Byte stores 0x11, 0x22, 0x33, 0x44 to offsets 0..3 of 0x10010020:
  - mem_write = 0001, 0010, 0100, 1000, mem_wdata = 0x11111111 etc.;
  - word load returns 0x11223344.
- Memory word 0x80FF7F01 at 0x10010000:
  - signed byte load at off 0 gives 0xFFFFFF80;
  - unsigned byte load at off 0 gives 0x00000080;
  - signed half load at off 2 gives 0x00007F01;
  - signed half load at off 0 gives 0xFFFF80FF.
- Errors each give resp_error=1, resp_rdata=0 at T+1 and mem_en never asserted:
  - half load at 0x10010001;
  - word store at 0x10010002;
  - req_size=11;
  - address 0x10012000;
  - address 0x1000FFFC.
- Handshake: req_valid held high continuously with back-to-back loads gives req_ready pattern 1,0,0,1 and exactly one resp_valid pulse per load.
- Reset mid-op: assert rst in RDWAIT, giving immediate resp_valid=0, req_ready=1 after release, and no stale response afterwards.
